// File: rtl/univ_shreg_pkg.sv
// ============================================================================
// Module      : univ_shreg_pkg
// Description : MODE encodings and counter-width helper for univ_shreg.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package univ_shreg_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROTL = 3'b100;
  localparam logic [2:0] MODE_ROTR = 3'b101;
  localparam logic [2:0] MODE_INV  = 3'b110;
  localparam logic [2:0] MODE_RSVD = 3'b111;

  // Bits needed to hold a count from 0 up to and including max_cnt.
  function automatic int cnt_width(input int max_cnt);
    return $clog2(max_cnt + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/shreg_cnt.sv
// ============================================================================
// Module      : shreg_cnt
// Description : Saturating up-counter with synchronous clear and enable.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module shreg_cnt
  import univ_shreg_pkg::*;
#(
  parameter int MAX_CNT = 8
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          clr,
  input  logic                          inc,
  input  logic                          en,
  output logic [cnt_width(MAX_CNT)-1:0] cnt,
  output logic                          done
);

  localparam int                CW    = cnt_width(MAX_CNT);
  localparam logic [CW-1:0]     c_MAX = CW'(MAX_CNT);

  logic [CW-1:0] r_cnt;
  logic          w_sat;

  assign w_sat = (r_cnt == c_MAX);

  // clr is honoured even when en is low so that a top-level clear wins over CE.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en && inc && !w_sat) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt  = r_cnt;
  assign done = w_sat;

endmodule

`default_nettype wire

// File: rtl/univ_shreg.sv
// ============================================================================
// Module      : univ_shreg
// Description : Universal shift register (load/shift/rotate/invert) with
//               saturating shift counter.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module univ_shreg
  import univ_shreg_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        CE,
  input  logic                        CLR,
  input  logic [2:0]                  MODE,
  input  logic [WIDTH-1:0]            D,
  input  logic                        SIN_SL,
  input  logic                        SIN_SR,
  output logic [WIDTH-1:0]            Q,
  output logic [WIDTH-1:0]            QN,
  output logic                        SOUT_SL,
  output logic                        SOUT_SR,
  output logic [cnt_width(WIDTH)-1:0] CNT,
  output logic                        DONE
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_is_shift;
  logic             w_cnt_clr;

  always_comb begin
    w_q_nxt    = r_q;
    w_is_shift = 1'b0;
    unique case (MODE)
      MODE_LOAD: w_q_nxt = D;
      MODE_SHL: begin
        w_q_nxt    = {r_q[WIDTH-2:0], SIN_SL};
        w_is_shift = 1'b1;
      end
      MODE_SHR: begin
        w_q_nxt    = {SIN_SR, r_q[WIDTH-1:1]};
        w_is_shift = 1'b1;
      end
      MODE_ROTL: begin
        w_q_nxt    = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
        w_is_shift = 1'b1;
      end
      MODE_ROTR: begin
        w_q_nxt    = {r_q[0], r_q[WIDTH-1:1]};
        w_is_shift = 1'b1;
      end
      MODE_INV: w_q_nxt = ~r_q;
      default:  w_q_nxt = r_q;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_q <= RST_VAL;
    end else if (CLR) begin
      r_q <= RST_VAL;
    end else if (CE) begin
      r_q <= w_q_nxt;
    end
  end

  // A LOAD restarts the shift count just like a clear.
  assign w_cnt_clr = CLR || (CE && (MODE == MODE_LOAD));

  shreg_cnt #(
    .MAX_CNT (WIDTH)
  ) u_cnt (
    .CLK  (CLK),
    .RST  (RST),
    .clr  (w_cnt_clr),
    .inc  (w_is_shift),
    .en   (CE),
    .cnt  (CNT),
    .done (DONE)
  );

  assign Q       = r_q;
  assign QN      = ~r_q;
  assign SOUT_SL = r_q[WIDTH-1];
  assign SOUT_SR = r_q[0];

endmodule

`default_nettype wire

// File: tb/tb_univ_shreg.sv
// ============================================================================
// Module      : tb_univ_shreg
// Description : Self-checking bench for univ_shreg (WIDTH=8).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_univ_shreg;

  localparam int W = 8;

  logic         CLK = 1'b0;
  logic         RST, CE, CLR, SIN_SL, SIN_SR;
  logic [2:0]   MODE;
  logic [W-1:0] D;
  logic [W-1:0] Q, QN;
  logic         SOUT_SL, SOUT_SR, DONE;
  logic [3:0]   CNT;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: register value and shifts since load/clear.
  int m_q;
  int m_cnt;

  univ_shreg #(.WIDTH(W), .RST_VAL(8'h00)) dut (
    .CLK(CLK), .RST(RST), .CE(CE), .CLR(CLR), .MODE(MODE), .D(D),
    .SIN_SL(SIN_SL), .SIN_SR(SIN_SR), .Q(Q), .QN(QN),
    .SOUT_SL(SOUT_SL), .SOUT_SR(SOUT_SR), .CNT(CNT), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

  // Apply one cycle of inputs, advance the reference model, sample #1 after the edge.
  task automatic drive(input logic ce, input logic clr, input int mode,
                       input int d, input logic sl, input logic sr);
    CE = ce; CLR = clr; MODE = mode[2:0]; D = d[7:0]; SIN_SL = sl; SIN_SR = sr;
    @(posedge CLK);
    #1;
    if (clr) begin
      m_q = 0; m_cnt = 0;
    end else if (ce) begin
      case (mode)
        1: begin m_q = d & 255; m_cnt = 0; end
        2: m_q = ((m_q * 2) + sl) % 256;
        3: m_q = (m_q / 2) + (sr ? 128 : 0);
        4: m_q = ((m_q * 2) % 256) + (m_q / 128);
        5: m_q = (m_q / 2) + ((m_q % 2) * 128);
        6: m_q = 255 - m_q;
        default: ;
      endcase
      if (mode >= 2 && mode <= 5 && m_cnt < W) m_cnt = m_cnt + 1;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; CE = 0; CLR = 0; MODE = 0; D = 0; SIN_SL = 0; SIN_SR = 0;
    m_q = 0; m_cnt = 0;
    repeat (2) @(posedge CLK);
    #1;
    n_cmp++;
    if ({Q, QN, CNT, DONE} !== {8'h00, 8'hFF, 4'd0, 1'b0}) begin
      n_err++;
      $display("FAIL reset: Q=%h QN=%h CNT=%0d DONE=%b required 00 ff 0 0", Q, QN, CNT, DONE);
    end
    RST = 1'b0;
  endtask

  task automatic test_load();
    drive(1, 0, 1, 'hA5, 0, 0);
    n_cmp++;
    if ({Q, QN, CNT, DONE} !== {8'hA5, 8'h5A, 4'd0, 1'b0}) begin
      n_err++;
      $display("FAIL load: Q=%h QN=%h CNT=%0d DONE=%b required a5 5a 0 0", Q, QN, CNT, DONE);
    end
  endtask

  task automatic test_shl_sequence();
    logic [7:0] exp_q  [8] = '{8'h4A, 8'h94, 8'h28, 8'h50, 8'hA0, 8'h40, 8'h80, 8'h00};
    logic       exp_so [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (SOUT_SL !== exp_so[i]) begin
        n_err++;
        $display("FAIL shl_sout[%0d]: got %b required %b", i, SOUT_SL, exp_so[i]);
      end
      drive(1, 0, 2, 0, 0, 0);
      n_cmp++;
      if (Q !== exp_q[i] || CNT !== 4'(i + 1)) begin
        n_err++;
        $display("FAIL shl_step[%0d]: Q=%h CNT=%0d required %h %0d", i, Q, CNT, exp_q[i], i + 1);
      end
    end
    n_cmp++;
    if (DONE !== 1'b1) begin
      n_err++;
      $display("FAIL shl_done: got %b required 1", DONE);
    end
    drive(1, 0, 2, 0, 0, 0);
    n_cmp++;
    if (CNT !== 4'd8 || DONE !== 1'b1) begin
      n_err++;
      $display("FAIL shl_saturate: CNT=%0d DONE=%b required 8 1", CNT, DONE);
    end
  endtask

  task automatic test_rot_inv();
    drive(1, 0, 1, 'h81, 0, 0);
    drive(1, 0, 5, 0, 0, 0);
    n_cmp++;
    if (Q !== 8'hC0) begin
      n_err++; $display("FAIL rotr: Q=%h required c0", Q);
    end
    drive(1, 0, 4, 0, 0, 0);
    n_cmp++;
    if (Q !== 8'h81) begin
      n_err++; $display("FAIL rotl: Q=%h required 81", Q);
    end
    drive(1, 0, 6, 0, 0, 0);
    n_cmp++;
    if (Q !== 8'h7E || QN !== 8'h81 || CNT !== 4'd2) begin
      n_err++; $display("FAIL inv: Q=%h QN=%h CNT=%0d required 7e 81 2", Q, QN, CNT);
    end
  endtask

  task automatic test_ce_clr();
    drive(1, 0, 1, 'h3C, 0, 0);
    drive(1, 0, 2, 0, 0, 0);
    drive(1, 0, 3, 0, 0, 0);
    drive(1, 0, 1, 'h3C, 0, 0);
    drive(1, 0, 6, 0, 0, 0);
    drive(1, 0, 6, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 2, 0, 1, 1);
    n_cmp++;
    if (Q !== 8'h3C || CNT !== 4'd0) begin
      n_err++; $display("FAIL ce_hold: Q=%h CNT=%0d required 3c 0", Q, CNT);
    end
    drive(1, 0, 3, 0, 0, 1);
    drive(0, 0, 3, 0, 0, 0);
    n_cmp++;
    if (Q !== 8'h9E || CNT !== 4'd1) begin
      n_err++; $display("FAIL ce_hold_cnt: Q=%h CNT=%0d required 9e 1", Q, CNT);
    end
    drive(0, 1, 2, 0, 1, 1);
    n_cmp++;
    if (Q !== 8'h00 || CNT !== 4'd0) begin
      n_err++; $display("FAIL clr_no_ce: Q=%h CNT=%0d required 00 0", Q, CNT);
    end
  endtask

  task automatic test_async_reset();
    drive(1, 0, 1, 'hF3, 0, 0);
    for (int i = 0; i < 3; i++) drive(1, 0, 2, 0, 1, 0);
    n_cmp++;
    if (CNT !== 4'd3 || Q !== 8'h9F) begin
      n_err++; $display("FAIL pre_async: Q=%h CNT=%0d required 9f 3", Q, CNT);
    end
    #2 RST = 1'b1;
    #1;
    n_cmp++;
    if ({Q, QN, CNT, DONE} !== {8'h00, 8'hFF, 4'd0, 1'b0}) begin
      n_err++;
      $display("FAIL async_rst: Q=%h QN=%h CNT=%0d DONE=%b required 00 ff 0 0", Q, QN, CNT, DONE);
    end
    #1 RST = 1'b0;
    m_q = 0; m_cnt = 0;
    drive(1, 0, 3, 0, 0, 1);
    n_cmp++;
    if (Q !== 8'h80 || CNT !== 4'd1) begin
      n_err++; $display("FAIL shr_after_rst: Q=%h CNT=%0d required 80 1", Q, CNT);
    end
  endtask

  task automatic test_reserved();
    drive(1, 0, 1, 'h5A, 0, 0);
    drive(1, 0, 4, 0, 0, 0);
    drive(1, 0, 5, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(1, 0, 7, 'hFF, 1, 1);
    n_cmp++;
    if (Q !== 8'h5A || CNT !== 4'd2) begin
      n_err++; $display("FAIL reserved: Q=%h CNT=%0d required 5a 2", Q, CNT);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(logic'($urandom_range(0, 4) != 0), logic'($urandom_range(0, 15) == 0),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
            logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)));
      n_cmp++;
      if (Q !== 8'(m_q) || QN !== ~8'(m_q) || CNT !== 4'(m_cnt) ||
          DONE !== (m_cnt == W) || SOUT_SL !== 1'(m_q / 128) || SOUT_SR !== 1'(m_q % 2)) begin
        n_err++;
        $display("FAIL random[%0d]: Q=%h CNT=%0d DONE=%b required Q=%h CNT=%0d",
                 i, Q, CNT, DONE, 8'(m_q), m_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_shl_sequence();
    test_rot_inv();
    test_ce_clr();
    test_async_reset();
    test_reserved();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
